// File: rtl/wb_commit_pkg.sv
// Shared types and helpers for the writeback commit unit.
//   LoadType_t   : {sign, size} load descriptor (size 0 byte, 1 half, 2/3 word)
//   TraceEntry_t : one committed-instruction trace record
//   WB_SEL_*     : write-data select encodings (3 aliases ALU)
//   load_extract : byte/half/word extraction with sign/zero extension
package wb_commit_pkg;

    typedef struct packed {
        logic       sign;
        logic [1:0] size;
    } LoadType_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } TraceEntry_t;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input LoadType_t   lt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        // Halfword access ignores off[0]; a misaligned half reads the containing half.
        h = off[1] ? word[31:16] : word[15:0];
        case (lt.size)
            LD_BYTE: r = lt.sign ? {{24{b[7]}}, b} : {24'h0, b};
            LD_HALF: r = lt.sign ? {{16{h[15]}}, h} : {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_commit_unit_trace_fifo.sv
// wb_trace_fifo: DEPTH-entry FIFO of TraceEntry_t records with a valid/ready pop side.
//   clk, rst (async, active-low)
//   push, push_data        : write side; ignored while full
//   pop_ready              : consumer accepts head when head_valid
//   head_valid, head_data  : current head record
//   count, full, empty     : occupancy
// Storage is reset so the head fields read as zero out of reset.
module wb_trace_fifo
    import wb_commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  TraceEntry_t              push_data,
    input  logic                     pop_ready,
    output logic                     head_valid,
    output TraceEntry_t              head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    TraceEntry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_valid = ~empty;
    assign head_data  = mem[rd_ptr];
    assign do_push    = push & ~full;
    assign do_pop     = head_valid & pop_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback-stage commit. Extracts load data, drives the GPR write
// port, counts retired instructions and (optionally) queues a trace record per commit.
//   Inputs : clk, rst (async, active-low), wb_* stage fields, trace_ready
//   Outputs: rf_we/rf_waddr/rf_wdata (combinational), wb_stall, instret,
//            trace_valid/trace_pc/trace_wen/trace_wnum/trace_wdata
// Build option WB_TRACE_EN: when defined, a DEPTH-entry trace FIFO is present and a
// full FIFO stalls the pipeline; otherwise the trace port is tied to zero and never stalls.
module wb_commit_unit
    import wb_commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [1:0]  wb_wbsel,
    input  logic [31:0] wb_pcadd1,
    input  logic [31:0] wb_aluout,
    input  logic [31:0] wb_dmout,
    input  logic [4:0]  wb_dst,
    input  logic [2:0]  wb_loadtype,
    input  logic        wb_regswr,
    input  logic [31:0] wb_excepttype,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_stall,
    output logic [31:0] instret,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [3:0]  trace_wen,
    output logic [4:0]  trace_wnum,
    output logic [31:0] trace_wdata
);
    LoadType_t   lt;
    logic [31:0] load_data;
    logic [31:0] sel_data;
    logic        live;
    logic        full;
    logic        commit;
    logic [31:0] instret_q;

    assign lt        = LoadType_t'(wb_loadtype);
    assign load_data = load_extract(wb_dmout, wb_aluout[1:0], lt);

    always_comb begin
        case (wb_wbsel)
            WB_SEL_LOAD: sel_data = load_data;
            WB_SEL_LINK: sel_data = wb_pcadd1;
            default:     sel_data = wb_aluout;
        endcase
    end

    // Excepted instructions are dropped outright, so they never wait on the FIFO.
    assign live     = wb_valid & (wb_excepttype == 32'h0);
    assign commit   = live & ~full;
    assign wb_stall = live & full;

    assign rf_we    = commit & wb_regswr & (wb_dst != 5'd0);
    assign rf_waddr = wb_dst;
    assign rf_wdata = sel_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        instret_q <= '0;
        else if (commit) instret_q <= instret_q + 32'd1;
    end
    assign instret = instret_q;

`ifdef WB_TRACE_EN
    TraceEntry_t                push_rec;
    TraceEntry_t                head_rec;
    logic [$clog2(DEPTH):0]     trace_count_unused;
    logic                       empty_unused;

    assign push_rec = '{pc: wb_pc, wen: (rf_we ? 4'hF : 4'h0), wnum: wb_dst, wdata: rf_wdata};

    wb_trace_fifo #(.DEPTH(DEPTH)) u_trace_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (commit),
        .push_data  (push_rec),
        .pop_ready  (trace_ready),
        .head_valid (trace_valid),
        .head_data  (head_rec),
        .count      (trace_count_unused),
        .full       (full),
        .empty      (empty_unused)
    );

    assign trace_pc    = head_rec.pc;
    assign trace_wen   = head_rec.wen;
    assign trace_wnum  = head_rec.wnum;
    assign trace_wdata = head_rec.wdata;
`else
    logic unused_trace_inputs;
    assign unused_trace_inputs = trace_ready ^ (|wb_pc);

    assign full        = 1'b0;
    assign trace_valid = 1'b0;
    assign trace_pc    = '0;
    assign trace_wen   = '0;
    assign trace_wnum  = '0;
    assign trace_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed self-checking bench for wb_commit_unit (DEPTH 4). Trace-port and
// back-pressure scenarios check the FIFO when WB_TRACE_EN is defined, and check the
// tied-off port otherwise.
module tb_wb_commit_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [1:0]  wb_wbsel;
    logic [31:0] wb_pcadd1;
    logic [31:0] wb_aluout;
    logic [31:0] wb_dmout;
    logic [4:0]  wb_dst;
    logic [2:0]  wb_loadtype;
    logic        wb_regswr;
    logic [31:0] wb_excepttype;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_stall;
    logic [31:0] instret;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [3:0]  trace_wen;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_instret = 32'h0;

    always #5 clk = ~clk;

    wb_commit_unit #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_wbsel(wb_wbsel),
        .wb_pcadd1(wb_pcadd1), .wb_aluout(wb_aluout), .wb_dmout(wb_dmout), .wb_dst(wb_dst),
        .wb_loadtype(wb_loadtype), .wb_regswr(wb_regswr), .wb_excepttype(wb_excepttype),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_stall(wb_stall),
        .instret(instret), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_wen(trace_wen), .trace_wnum(trace_wnum),
        .trace_wdata(trace_wdata)
    );

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] sel,
                         input logic [31:0] pca, input logic [31:0] alu, input logic [31:0] dm,
                         input logic [4:0] dst, input logic [2:0] lt, input logic rw,
                         input logic [31:0] exc);
        wb_valid = v; wb_pc = pc; wb_wbsel = sel; wb_pcadd1 = pca; wb_aluout = alu;
        wb_dmout = dm; wb_dst = dst; wb_loadtype = lt; wb_regswr = rw; wb_excepttype = exc;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; trace_ready = 1'b0; idle();
        #12;
        n_checks++;
        if (instret !== 32'h0) begin n_fail++; $display("FAIL reset_instret: got %h want 0", instret); end
        n_checks++;
        if ({trace_valid, trace_pc, trace_wen, trace_wnum, trace_wdata} !== 74'h0) begin
            n_fail++; $display("FAIL reset_trace: valid %b pc %h", trace_valid, trace_pc);
        end
        n_checks++;
        if ({rf_we, wb_stall} !== 2'b00) begin n_fail++; $display("FAIL reset_we_stall: got %b want 00", {rf_we, wb_stall}); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_extract();
        logic [31:0] exp_d [3] = '{32'h0000_007F, 32'hFFFF_80FF, 32'h0000_80FF};
        logic [31:0] alus  [3] = '{32'h0000_2001, 32'h0000_2002, 32'h0000_2002};
        logic [2:0]  lts   [3] = '{3'b100, 3'b101, 3'b001};
        trace_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(4*i), 2'd1, 32'h0, alus[i], 32'h80FF_7F01, 5'd3,
                  lts[i], 1'b1, 32'h0);
            #1;
            n_checks++;
            if (rf_wdata !== exp_d[i] || rf_we !== 1'b1) begin
                n_fail++; $display("FAIL load_%0d: we %b data %h want 1 %h", i, rf_we, rf_wdata, exp_d[i]);
            end
            tick();
            exp_instret++;
`ifdef WB_TRACE_EN
            n_checks++;
            if (trace_valid !== 1'b1 || trace_pc !== 32'h200 + 32'(4*i) || trace_wdata !== exp_d[i]) begin
                n_fail++; $display("FAIL load_trace_%0d: v %b pc %h data %h", i, trace_valid, trace_pc, trace_wdata);
            end
`endif
        end
        n_checks++;
        if (instret !== exp_instret) begin n_fail++; $display("FAIL load_instret: got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_link();
        drive(1'b1, 32'h300, 2'd2, 32'hBFC0_0008, 32'h1234, 32'h0, 5'd31, 3'd2, 1'b1, 32'h0);
        #1;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'hBFC0_0008) begin
            n_fail++; $display("FAIL link_r31: we %b addr %0d data %h", rf_we, rf_waddr, rf_wdata);
        end
        tick(); exp_instret++;
`ifdef WB_TRACE_EN
        n_checks++;
        if (trace_wen !== 4'hF || trace_wnum !== 5'd31) begin
            n_fail++; $display("FAIL link_r31_trace: wen %h wnum %0d want F 31", trace_wen, trace_wnum);
        end
`endif
        drive(1'b1, 32'h304, 2'd2, 32'hBFC0_0008, 32'h1234, 32'h0, 5'd0, 3'd2, 1'b1, 32'h0);
        #1;
        n_checks++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL link_r0_we: got %b want 0", rf_we); end
        tick(); exp_instret++;
`ifdef WB_TRACE_EN
        n_checks++;
        if (trace_valid !== 1'b1 || trace_wen !== 4'h0 || trace_pc !== 32'h304) begin
            n_fail++; $display("FAIL link_r0_trace: v %b wen %h pc %h", trace_valid, trace_wen, trace_pc);
        end
`endif
        n_checks++;
        if (instret !== exp_instret) begin n_fail++; $display("FAIL link_instret: got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_exception();
        drive(1'b1, 32'h400, 2'd0, 32'h0, 32'hAAAA, 32'h0, 5'd7, 3'd2, 1'b1, 32'h10);
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || wb_stall !== 1'b0) begin
            n_fail++; $display("FAIL exc_comb: we %b stall %b want 0 0", rf_we, wb_stall);
        end
        tick();
        idle();
        n_checks++;
        if (instret !== exp_instret || trace_valid !== 1'b0) begin
            n_fail++; $display("FAIL exc_effect: instret %0d want %0d trace_valid %b want 0", instret, exp_instret, trace_valid);
        end
    endtask

    task automatic test_back_to_back();
        trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4*i), 2'd0, 32'h0, 32'h1000 + 32'(i), 32'h0, 5'(i+1), 3'd2, 1'b1, 32'h0);
            #1;
            n_checks++;
            if (wb_stall !== 1'b0 || rf_we !== 1'b1) begin
                n_fail++; $display("FAIL bp_fill_%0d: stall %b we %b want 0 1", i, wb_stall, rf_we);
            end
            tick(); exp_instret++;
        end
        drive(1'b1, 32'h110, 2'd0, 32'h0, 32'h1004, 32'h0, 5'd5, 3'd2, 1'b1, 32'h0);
        #1;
`ifdef WB_TRACE_EN
        n_checks++;
        if (wb_stall !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL bp_full: stall %b we %b want 1 0", wb_stall, rf_we);
        end
        tick();
        n_checks++;
        if (instret !== exp_instret || wb_stall !== 1'b1) begin
            n_fail++; $display("FAIL bp_held: instret %0d want %0d stall %b", instret, exp_instret, wb_stall);
        end
        trace_ready = 1'b1;
        #1;
        n_checks++;
        if (trace_pc !== 32'h100 || trace_wdata !== 32'h1000) begin
            n_fail++; $display("FAIL bp_head0: pc %h data %h want 100 1000", trace_pc, trace_wdata);
        end
        tick();
        trace_ready = 1'b0;
        #1;
        n_checks++;
        if (wb_stall !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd5) begin
            n_fail++; $display("FAIL bp_release: stall %b we %b addr %0d", wb_stall, rf_we, rf_waddr);
        end
        tick(); exp_instret++;
        idle();
        trace_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            #1;
            n_checks++;
            if (trace_valid !== 1'b1 || trace_pc !== 32'h100 + 32'(4*i) || trace_wnum !== 5'(i+1) ||
                trace_wdata !== 32'h1000 + 32'(i)) begin
                n_fail++; $display("FAIL bp_drain_%0d: v %b pc %h wnum %0d data %h", i, trace_valid, trace_pc, trace_wnum, trace_wdata);
            end
            tick();
        end
        n_checks++;
        if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: trace_valid %b want 0", trace_valid); end
`else
        n_checks++;
        if (wb_stall !== 1'b0 || rf_we !== 1'b1 || trace_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_notrace: stall %b we %b tv %b want 0 1 0", wb_stall, rf_we, trace_valid);
        end
        tick(); exp_instret++;
        idle();
        trace_ready = 1'b1;
`endif
        n_checks++;
        if (instret !== exp_instret) begin n_fail++; $display("FAIL bp_instret: got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_wrap();
        idle();
        force dut.instret_q = 32'hFFFF_FFFF;
        tick();
        release dut.instret_q;
        #1;
        n_checks++;
        if (instret !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preset: got %h want FFFFFFFF", instret); end
        drive(1'b1, 32'h500, 2'd0, 32'h0, 32'h5, 32'h0, 5'd2, 3'd2, 1'b1, 32'h0);
        tick();
        idle();
        n_checks++;
        if (instret !== 32'h0) begin n_fail++; $display("FAIL wrap: got %h want 0", instret); end
        tick();
    endtask

    task automatic test_async_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h600 + 32'(4*i), 2'd0, 32'h0, 32'h60 + 32'(i), 32'h0, 5'd9, 3'd2, 1'b1, 32'h0);
            tick();
        end
        idle();
        n_checks++;
        if (instret !== 32'd3) begin n_fail++; $display("FAIL ar_pre_instret: got %0d want 3", instret); end
`ifdef WB_TRACE_EN
        n_checks++;
        if (trace_valid !== 1'b1 || trace_pc !== 32'h600) begin
            n_fail++; $display("FAIL ar_pre_trace: v %b pc %h want 1 600", trace_valid, trace_pc);
        end
`endif
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (trace_valid !== 1'b0 || instret !== 32'h0 || trace_pc !== 32'h0) begin
            n_fail++; $display("FAIL ar_during: v %b instret %h pc %h want 0 0 0", trace_valid, instret, trace_pc);
        end
        @(negedge clk);
        rst = 1'b1;
        trace_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (trace_valid !== 1'b0 || instret !== 32'h0) begin
            n_fail++; $display("FAIL ar_after: v %b instret %h want 0 0", trace_valid, instret);
        end
    endtask

    initial begin
        test_reset();
        test_load_extract();
        test_link();
        test_exception();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Writeback-stage commit unit sitting at the far end of the MEM/WB pipeline register. Consumes the WB-stage fields it holds, performs load-data extraction, selects and drives the GPR write port, and counts retired instructions. Optionally pushes one record per committed instruction into a trace FIFO drained by a valid/ready debug port. Back-pressures the pipeline when that FIFO is full.

## Interface
- DEPTH, 4: trace FIFO entries (power of two, ≥2).
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wb_valid  in  1  WB stage holds a real instruction (0 = bubble/flushed).
- wb_pc  in  32  PC of the WB instruction.
- wb_wbsel  in  2  write-data select: 0 ALU, 1 load, 2 link (wb_pcadd1), 3 ALU.
- wb_pcadd1  in  32  link value.
- wb_aluout  in  32  ALU result; bits [1:0] are the load byte offset.
- wb_dmout  in  32  raw aligned data-memory word.
- wb_dst  in  5  destination GPR.
- wb_loadtype  in  3  {sign, size[1:0]}; size 0 byte, 1 half, 2 word.
- wb_regswr  in  1  instruction writes a GPR.
- wb_excepttype  in  32  nonzero = excepted, no architectural effect.
- rf_we  out  1  GPR write enable.
- rf_waddr  out  5  GPR write address.
- rf_wdata  out  32  GPR write data.
- wb_stall  out  1  hold MEM/WB and all earlier stages this cycle.
- instret  out  32  retired-instruction count.
- trace_valid  out  1  trace head valid.
- trace_ready  in  1  consumer accepts head.
- trace_pc  out  32  head PC.
- trace_wen  out  4  head byte-write mask (4'hF or 4'h0).
- trace_wnum  out  5  head destination.
- trace_wdata  out  32  head data.

## Operation
- commit = wb_valid & (wb_excepttype == 0) & ~full. Excepted instructions never commit, never stall.
- wb_stall = wb_valid & (wb_excepttype == 0) & full (combinational, from registered full only).
- rf_we = commit & wb_regswr & (wb_dst != 0); rf_waddr = wb_dst; rf_wdata = selected data (combinational).
- Load extract: byte = wb_dmout[8*off +: 8], half = wb_dmout[16*off[1] +: 16] (off[0] ignored), word = full; sign=1 sign-extends, else zero-extends. size 3 treated as word.
- instret increments by 1 on every commit, wraps 32'hFFFF_FFFF → 0.
- Trace push on commit: {wb_pc, rf_we ? 4'hF : 4'h0, wb_dst, rf_wdata}. Non-writing instructions still push (wen 0).
- Trace pop when trace_valid & trace_ready. Head fields stable while trace_valid & ~trace_ready.
- full = (count == DEPTH); push and pop in the same cycle when not full: count unchanged. When full, no push regardless of trace_ready that cycle.

## Timing
- Reset (rst low, async): count 0, pointers 0, instret 0, trace_valid 0, trace_* data 0. rf_we/wb_stall combinational, 0 whenever wb_valid 0.
- GPR write: zero latency, same cycle the instruction is in WB.
- Trace: entry visible at trace_valid one cycle after commit; FIFO throughput 1/cycle.
- Full → stall: the stalled instruction commits in the cycle after the first pop frees an entry.
- Reset mid-operation discards all queued records.

## Configuration
- WB_TRACE_EN defined: FIFO, trace port and stall as above.
- Undefined: no FIFO storage; full constant 0, wb_stall 0, trace_valid 0, trace_* outputs 0, trace_ready ignored. rf write and instret unchanged.

## Structure
- Shared package: LoadType_t struct {sign, size}, WB_SEL_ALU/LOAD/LINK constants, TraceEntry_t struct {pc, wen, wnum, wdata}.
- Sub-module wb_trace_fifo (parameterized DEPTH, TraceEntry_t payload, count/full/empty, valid/ready pop).

## Test plan
- Load extract: dmout 32'h80FF_7F01, aluout low bits 2'b01, loadtype {1,0} → rf_wdata 32'h0000_007F; loadtype {1,1}, off 2'b10 → 32'hFFFF_80FF; {0,1} → 32'h0000_80FF.
- Link: wbsel 2, pcadd1 32'hBFC0_0008, dst 31 → rf_we 1, rf_waddr 31, rf_wdata 32'hBFC0_0008; dst 0 → rf_we 0, trace_wen 0.
- Exception: excepttype 32'h10, regswr 1 → rf_we 0, no push, instret unchanged, wb_stall 0.
- Back-pressure (DEPTH 4): trace_ready 0, 5 valid writes → first 4 commit, 5th wb_stall 1; raise trace_ready 1 cycle → 5th commits next cycle, records pop in program order.
- Wrap: force instret 32'hFFFF_FFFF, one commit → 0.
- Async reset with 3 queued records → trace_valid 0 immediately, instret 0, no record after release.
